// File: rtl/clk_divider_pkg.sv
// rtl/clk_divider_pkg.sv - shared constants and sizing helpers for the integer clock divider
//
// Purpose:
//   Width and threshold computations used by clk_divider and its mod-N counter.
//   Both helpers are constant functions, so they are evaluated at elaboration.
//
// Contents:
//   DIV_MIN / DIV_MAX - legal range of the division ratio
//   cnt_width(div)    - counter width, max(1, clog2(div))
//   hi_count(div, d)  - number of rising-edge cycles the registered output is high
//                       in each period; d selects the half-cycle-extended build

package clk_divider_pkg;

    localparam int DIV_MIN = 2;
    localparam int DIV_MAX = 65535;

    // At least one bit, even though clog2 of 1 is 0.
    function automatic int cnt_width(input int div);
        int w;
        w = $clog2(div);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    // Default build: ceil(div/2), so odd ratios are high one cycle longer than low.
    // With the falling-edge extension on an odd ratio, the registered part is
    // floor(div/2) and the negedge flop adds the missing half cycle.
    function automatic int hi_count(input int div, input bit duty50);
        int hi;
        if (duty50 && ((div % 2) == 1)) begin
            hi = div / 2;
        end else begin
            hi = (div + 1) / 2;
        end
        return hi;
    endfunction

endpackage : clk_divider_pkg

// File: rtl/clk_divider_modn_counter.sv
// rtl/clk_divider_modn_counter.sv - free-running mod-N counter with wrap indication
//
// Purpose:
//   Counts 0, 1, ..., DIV-1, 0, ... on every rising edge of clk. The counter
//   can never hold a value >= DIV, because it is cleared on reset and only
//   ever moves by +1 or wraps to 0 from DIV-1.
//
// Parameters:
//   DIV    - modulus, legal range DIV_MIN..DIV_MAX
//
// Ports:
//   clk    in   1   counting clock, rising edge
//   resetb in   1   synchronous active-low reset, clears the count
//   cnt    out  CW  current count, CW = cnt_width(DIV)
//   wrap   out  1   high while cnt == DIV-1, i.e. the next edge wraps to 0

module clk_divider_modn_counter
    import clk_divider_pkg::*;
#(
    parameter int  DIV = 5,
    localparam int CW  = cnt_width(DIV)
) (
    input  logic          clk,
    input  logic          resetb,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if ((DIV < DIV_MIN) || (DIV > DIV_MAX)) begin : g_div_range_err
        $error("clk_divider_modn_counter: DIV=%0d outside legal range %0d..%0d",
               DIV, DIV_MIN, DIV_MAX);
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = (cnt_q == LAST);

endmodule : clk_divider_modn_counter

// File: rtl/clk_divider.sv
// rtl/clk_divider.sv - integer clock divider with registered, glitch-free output
//
// Purpose:
//   Produces clk_out with a period of DIV input clock cycles. The output is a
//   flop (or, for the odd-ratio 50% build, an OR of two flops whose switching
//   edges never coincide), so it is safe to use as a clock.
//   After reset release the first rising edge drives clk_out high; it stays
//   high for HI cycles and low for DIV-HI cycles.
//
// Build option:
//   CLK_DIV_DUTY50_EN - when defined and DIV is odd, a falling-edge flop
//   stretches the high phase by half a cycle to give exact 50% duty.
//   When undefined there is no falling-edge logic at all.
//
// Parameters:
//   DIV     - division ratio, 2..65535; elaboration fails outside that range
//
// Ports:
//   clk     in   1   input clock
//   resetb  in   1   synchronous active-low reset; clk_out reads 0 while low
//   clk_out out  1   divided clock

module clk_divider
    import clk_divider_pkg::*;
#(
    parameter int DIV = 5
) (
    input  logic clk,
    input  logic resetb,
    output logic clk_out
);

`ifdef CLK_DIV_DUTY50_EN
    localparam bit DUTY50_EN = 1'b1;
`else
    localparam bit DUTY50_EN = 1'b0;
`endif

    localparam int            CW   = cnt_width(DIV);
    localparam int            HI   = hi_count(DIV, DUTY50_EN);
    localparam logic [CW-1:0] HI_C = CW'(HI);

    if ((DIV < DIV_MIN) || (DIV > DIV_MAX)) begin : g_div_range_err
        $error("clk_divider: DIV=%0d outside legal range %0d..%0d",
               DIV, DIV_MIN, DIV_MAX);
    end

    logic [CW-1:0] cnt;
    logic          wrap_unused;

    clk_divider_modn_counter #(
        .DIV    (DIV)
    ) u_cnt (
        .clk    (clk),
        .resetb (resetb),
        .cnt    (cnt),
        .wrap   (wrap_unused)
    );

    // The compare uses the count before this edge's increment, which is what
    // makes the first post-reset edge (cnt == 0) produce a high output.
    logic clk_out_q;
    logic clk_out_d;

    always_comb begin
        clk_out_d = (cnt < HI_C);
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            clk_out_q <= 1'b0;
        end else begin
            clk_out_q <= clk_out_d;
        end
    end

`ifdef CLK_DIV_DUTY50_EN
    if ((DIV % 2) == 1) begin : g_duty50
        // neg_q follows clk_out_q half a cycle late. clk_out_q rises while
        // neg_q is already low and falls while neg_q is still high, so the OR
        // has a single rise on a rising edge and a single fall on the
        // following falling edge.
        logic neg_q;

        always_ff @(negedge clk) begin
            if (!resetb) begin
                neg_q <= 1'b0;
            end else begin
                neg_q <= clk_out_q;
            end
        end

        assign clk_out = clk_out_q | neg_q;
    end else begin : g_plain
        assign clk_out = clk_out_q;
    end
`else
    assign clk_out = clk_out_q;
`endif

endmodule : clk_divider

// File: tb/tb_clk_divider.sv
// tb/tb_clk_divider.sv - directed self-checking bench for clk_divider (DIV = 5, 2, 8, 4)

module tb_clk_divider;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstb5 = 1'b0;
    logic rstb2 = 1'b0;
    logic rstb8 = 1'b0;
    logic rstb4 = 1'b0;
    logic out5, out2, out8, out4;

`ifdef CLK_DIV_DUTY50_EN
    localparam bit DUTY50 = 1'b1;
`else
    localparam bit DUTY50 = 1'b0;
`endif

    clk_divider #(.DIV(5)) dut5 (.clk(clk), .resetb(rstb5), .clk_out(out5));
    clk_divider #(.DIV(2)) dut2 (.clk(clk), .resetb(rstb2), .clk_out(out2));
    clk_divider #(.DIV(8)) dut8 (.clk(clk), .resetb(rstb8), .clk_out(out8));
    clk_divider #(.DIV(4)) dut4 (.clk(clk), .resetb(rstb4), .clk_out(out4));

    task automatic step_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic step_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step_pos();
            checks++;
            if (out5 !== 1'b0) begin
                errors++;
                $display("FAIL reset_div5 edge %0d: got %b expected 0", i, out5);
            end
            checks++;
            if (out2 !== 1'b0 || out8 !== 1'b0 || out4 !== 1'b0) begin
                errors++;
                $display("FAIL reset_others edge %0d: got %b%b%b expected 000", i, out2, out8, out4);
            end
        end
        rstb5 = 1'b1;
    endtask

    // Ten full periods: posedge samples are 3 high / 2 low in both builds.
    // Half a cycle after the third high edge the 50% build has already fallen.
    task automatic test_div5_periods();
        logic prev;
        logic exp_pos, exp_neg;
        int   rises;
        prev  = 1'b0;
        rises = 0;
        for (int k = 0; k < 50; k++) begin
            step_pos();
            exp_pos = ((k % 5) < 3);
            checks++;
            if (out5 !== exp_pos) begin
                errors++;
                $display("FAIL div5_pos k=%0d: got %b expected %b", k, out5, exp_pos);
            end
            if (out5 === 1'b1 && prev === 1'b0) rises++;
            prev = out5;
            step_neg();
            exp_neg = DUTY50 ? ((k % 5) < 2) : ((k % 5) < 3);
            checks++;
            if (out5 !== exp_neg) begin
                errors++;
                $display("FAIL div5_neg k=%0d: got %b expected %b", k, out5, exp_neg);
            end
        end
        checks++;
        if (rises != 10) begin
            errors++;
            $display("FAIL div5_period_count: got %0d rises expected 10", rises);
        end
    endtask

    task automatic test_div2();
        logic exp;
        rstb2 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step_pos();
            exp = ((k % 2) == 0);
            checks++;
            if (out2 !== exp) begin
                errors++;
                $display("FAIL div2 k=%0d: got %b expected %b", k, out2, exp);
            end
        end
    endtask

    task automatic test_div8();
        logic exp;
        int   max_cnt;
        max_cnt = 0;
        rstb8 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step_pos();
            exp = ((k % 8) < 4);
            checks++;
            if (out8 !== exp) begin
                errors++;
                $display("FAIL div8 k=%0d: got %b expected %b", k, out8, exp);
            end
            if (int'(dut8.u_cnt.cnt) > max_cnt) max_cnt = int'(dut8.u_cnt.cnt);
        end
        checks++;
        if (max_cnt != 7) begin
            errors++;
            $display("FAIL div8_cnt_max: got %0d expected 7", max_cnt);
        end
    endtask

    task automatic test_mid_reset();
        logic exp;
        // Re-synchronise, then one edge puts cnt at 1 inside the high phase.
        rstb5 = 1'b0;
        step_pos();
        rstb5 = 1'b1;
        step_pos();
        checks++;
        if (out5 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got %b expected 1", out5);
        end
        rstb5 = 1'b0;
        step_pos();
        checks++;
        if (out5 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_forced_low: got %b expected 0", out5);
        end
        rstb5 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step_pos();
            exp = ((k % 5) < 3);
            checks++;
            if (out5 !== exp) begin
                errors++;
                $display("FAIL midrst_restart k=%0d: got %b expected %b", k, out5, exp);
            end
        end
    endtask

    // Even ratio: identical waveform in both builds, at both clock phases.
    task automatic test_div4();
        logic exp;
        rstb4 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step_pos();
            exp = ((k % 4) < 2);
            checks++;
            if (out4 !== exp) begin
                errors++;
                $display("FAIL div4_pos k=%0d: got %b expected %b", k, out4, exp);
            end
            step_neg();
            checks++;
            if (out4 !== exp) begin
                errors++;
                $display("FAIL div4_neg k=%0d: got %b expected %b", k, out4, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_div5_periods();
        test_div2();
        test_div8();
        test_mid_reset();
        test_div4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clk_divider

// File: doc/clk_divider.md
Name: clk_divider

Overview:
- Integer clock divider producing a divided clock from the input clock `clk`.
- Used in the amplifier front-end to derive the slow I2C state-machine clock (DIV=5) from the system clock.
- Output is a registered, glitch-free level, usable as a clock.
- Odd-ratio 50% duty is available as a compile option.

Parameters:
- DIV, default 5: division ratio. Output period = DIV input clock cycles. Legal range 2..65535; elaboration fails with an error if DIV < 2.

Ports:
- clk  input  1  input clock; all state on rising edge (falling-edge flop only with the optional feature)
- resetb  input  1  synchronous, active-low reset
- clk_out  output  1  divided clock

Behaviour:
- Reset: resetb is synchronous, active-low, on clock clk.
- Constants:
  - CW = max(1, clog2(DIV)) is the counter width.
  - HI = ceil(DIV/2) = (DIV+1)/2 in the default build.
- Counter cnt[CW-1:0]:
  - Increments each rising edge.
  - Wraps from DIV-1 to 0.
  - Never holds a value ≥ DIV.
- Output register clk_out_q:
  - On each non-reset rising edge, clk_out_q <= (cnt < HI), evaluated with the pre-update cnt.
  - cnt <= (cnt == DIV-1) ? 0 : cnt+1.
- clk_out = clk_out_q; no combinational path from inputs.
- Reset: while resetb=0 at a rising edge, cnt <= 0 and clk_out_q <= 0. clk_out therefore reads 0 during reset.
- After reset release:
  - The first rising edge with resetb=1 drives clk_out high.
  - clk_out stays high for HI cycles, then low for DIV-HI cycles, repeating with period DIV.
- Example, DIV=5: edges 1-3 high, edges 4-5 low, edge 6 high again.
- Example, DIV=2: toggles every edge.
- Reset mid-period: the next edge with resetb=0 forces cnt=0 and clk_out=0 regardless of phase. Restart is deterministic as above.
- Even DIV: exact 50% duty.
- Odd DIV, default build: high one cycle longer than low.
- Unlisted corners: no handshake. Output frequency is fixed; there is no runtime ratio change.

Optional Feature:
- Macro: CLK_DIV_DUTY50_EN.
- Defined, with odd DIV:
  - HI = floor(DIV/2).
  - Add a falling-edge flop neg_q <= clk_out_q.
  - neg_q is cleared on a falling edge where resetb=0.
  - clk_out = clk_out_q | neg_q, giving high DIV/2 cycles (x.5) and low DIV/2 cycles, i.e. exact 50% duty.
  - The OR is glitch-free because the rise of clk_out_q and the fall of neg_q never coincide.
- Defined, with even DIV: identical to the default build; neg_q is not instantiated.
- Not defined: no falling-edge logic anywhere; behaviour exactly as in Behaviour.

Decomposition:
- Package clk_divider_pkg holds:
  - function cnt_width(div) returning max(1, clog2(div));
  - function hi_count(div, duty50) returning the HI constant.
- One natural sub-module: clk_divider_modn_counter (parameter DIV, ports clk, resetb, cnt, wrap pulse), a reusable mod-N counter.
- The top holds the compare register and the optional falling-edge flop.

Test Plan:
- DIV=5, hold resetb=0 for 3 edges, then release -> clk_out=0 during reset; after release, high 3 edges, low 2 edges, period 5; count 10 periods exactly.
- DIV=2 -> clk_out alternates 1,0,1,0 on successive edges from the first post-reset edge.
- DIV=8 -> 4 high / 4 low; cnt never exceeds 7; period 8 over 100 cycles.
- DIV=5, assert resetb=0 for 1 edge mid-high-phase (cnt=1) -> clk_out=0 on that edge; after release, a fresh 3-high/2-low sequence.
- CLK_DIV_DUTY50_EN, DIV=5 -> measured high time 2.5 clk periods, low time 2.5, no glitches.
- CLK_DIV_DUTY50_EN, DIV=4 -> identical waveform to the default build.
- DIV=1 -> elaboration error.
